ltc2333_scan_controller: RTL and testbench

- Single-clock sequencer for one LTC2333 8-channel 18-bit SoftSpan ADC.
- Per trigger it runs one conversion: pulses CNV, waits out BUSY, then runs a DDR SCKI readout frame of one bit per SCKI edge.
- It captures the 24-bit SDO word (18-bit data, 3-bit channel ID, 3-bit SoftSpan) and optionally shifts a new SoftSpan sequence on SDI in the same frame.
- It checks each returned channel/span against the expected sequence position; it sits between the trigger/timing logic and the readout FIFO.

---
 rtl/ltc2333_scan_controller.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_ltc2333_scan_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2333_scan_controller.sv
// Conversion sequencer for a single LTC2333 ADC: CNV pulse, BUSY handshake,
// DDR SCKI readout of the 24-bit result word with optional SoftSpan sequence
// programming on SDI, and a check of each returned channel/span against the
// programmed sequence.
module ltc2333_scan_controller #(
    parameter int unsigned SCK_HALF = 4,
    parameter int unsigned CNV_HIGH = 4,
    parameter int unsigned BUSY_TO  = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig,
    input  logic        cfg_update,
    input  logic [3:0]  cfg_num,
    input  logic [47:0] cfg_list,
    output logic        cnv,
    input  logic        busy,
    output logic        scki,
    output logic        sdi,
    input  logic        sdo,
    output logic        ready,
    output logic        res_valid,
    output logic [17:0] res_data,
    output logic [2:0]  res_chan,
    output logic [2:0]  res_span,
    output logic        seq_err,
    output logic        timeout_err,
    output logic        trig_overrun
);

    localparam int unsigned CNT_MAX =
        (BUSY_TO > CNV_HIGH) ? ((BUSY_TO > SCK_HALF) ? BUSY_TO : SCK_HALF)
                             : ((CNV_HIGH > SCK_HALF) ? CNV_HIGH : SCK_HALF);
    localparam int unsigned CNT_W  = $clog2(CNT_MAX + 1);
    localparam int unsigned K_W    = 7;
    localparam int unsigned WORD_W = 24;
    localparam int unsigned LIST_W = 48;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNV_PULSE,
        S_WAIT_BUSY_HI,
        S_WAIT_BUSY_LO,
        S_SHIFT,
        S_OUTPUT
    } state_t;

    // Clamp the entry count into 1..8.
    function automatic logic [3:0] norm_num(input logic [3:0] n);
        logic [3:0] r;
        r = n;
        if (n == 4'd0) r = 4'd1;
        else if (n > 4'd8) r = 4'd8;
        return r;
    endfunction

    // SDI bit for half-period k: byte j = {1,0,chan_j,span_j}, MSB first.
    function automatic logic sdi_bit(input logic [K_W-1:0] k, input logic ld,
                                     input logic [3:0] num, input logic [LIST_W-1:0] list);
        logic [5:0] entry;
        logic [7:0] byte_v;
        logic       b;
        entry  = 6'(list >> (6 * 32'(k[5:3])));
        byte_v = {2'b10, entry};
        b      = 1'b0;
        if (ld && (k < {num, 3'b000})) b = byte_v[3'd7 - k[2:0]];
        return b;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [K_W-1:0]      e_q, e_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                cnv_q, cnv_d;
    logic                scki_q, scki_d;
    logic                sdi_q, sdi_d;
    logic                ready_q, ready_d;
    logic                res_valid_q, res_valid_d;
    logic [17:0]         res_data_q, res_data_d;
    logic [2:0]          res_chan_q, res_chan_d;
    logic [2:0]          res_span_q, res_span_d;
    logic                seq_err_q, seq_err_d;
    logic                timeout_q, timeout_d;
    logic                overrun_q, overrun_d;
    logic [3:0]          shadow_num_q, shadow_num_d;
    logic [LIST_W-1:0]   shadow_list_q, shadow_list_d;
    logic                pending_q, pending_d;
    logic                frame_load_q, frame_load_d;
    logic [3:0]          frame_num_q, frame_num_d;
    logic [LIST_W-1:0]   frame_list_q, frame_list_d;
    logic [3:0]          act_num_q, act_num_d;
    logic [LIST_W-1:0]   act_list_q, act_list_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic [2:0]          ptr_q, ptr_d;
    logic                busy_s1_q, busy_s2_q;
    logic                sdo_s1_q, sdo_s2_q;
    logic                half_last;
    logic [5:0]          exp_entry;

    assign half_last = (cnt_q == CNT_W'(SCK_HALF - 1));
    assign exp_entry = 6'(act_list_q >> (6 * 32'(ptr_q)));

    // Two-flop synchronizers for the asynchronous ADC outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_s1_q <= 1'b0;
            busy_s2_q <= 1'b0;
            sdo_s1_q  <= 1'b0;
            sdo_s2_q  <= 1'b0;
        end else begin
            busy_s1_q <= busy;
            busy_s2_q <= busy_s1_q;
            sdo_s1_q  <= sdo;
            sdo_s2_q  <= sdo_s1_q;
        end
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            k_q           <= '0;
            e_q           <= '0;
            word_q        <= '0;
            cnv_q         <= 1'b0;
            scki_q        <= 1'b0;
            sdi_q         <= 1'b0;
            ready_q       <= 1'b1;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_chan_q    <= '0;
            res_span_q    <= '0;
            seq_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
            shadow_num_q  <= '0;
            shadow_list_q <= '0;
            pending_q     <= 1'b0;
            frame_load_q  <= 1'b0;
            frame_num_q   <= '0;
            frame_list_q  <= '0;
            act_num_q     <= '0;
            act_list_q    <= '0;
            cfg_valid_q   <= 1'b0;
            ptr_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            k_q           <= k_d;
            e_q           <= e_d;
            word_q        <= word_d;
            cnv_q         <= cnv_d;
            scki_q        <= scki_d;
            sdi_q         <= sdi_d;
            ready_q       <= ready_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_chan_q    <= res_chan_d;
            res_span_q    <= res_span_d;
            seq_err_q     <= seq_err_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
            shadow_num_q  <= shadow_num_d;
            shadow_list_q <= shadow_list_d;
            pending_q     <= pending_d;
            frame_load_q  <= frame_load_d;
            frame_num_q   <= frame_num_d;
            frame_list_q  <= frame_list_d;
            act_num_q     <= act_num_d;
            act_list_q    <= act_list_d;
            cfg_valid_q   <= cfg_valid_d;
            ptr_q         <= ptr_d;
        end
    end

    // Next-state and output logic for the conversion sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        k_d           = k_q;
        e_d           = e_q;
        word_d        = word_q;
        scki_d        = scki_q;
        sdi_d         = sdi_q;
        res_valid_d   = 1'b0;
        res_data_d    = res_data_q;
        res_chan_d    = res_chan_q;
        res_span_d    = res_span_q;
        seq_err_d     = 1'b0;
        timeout_d     = 1'b0;
        overrun_d     = 1'b0;
        shadow_num_d  = shadow_num_q;
        shadow_list_d = shadow_list_q;
        pending_d     = pending_q;
        frame_load_d  = frame_load_q;
        frame_num_d   = frame_num_q;
        frame_list_d  = frame_list_q;
        act_num_d     = act_num_q;
        act_list_d    = act_list_q;
        cfg_valid_d   = cfg_valid_q;
        ptr_d         = ptr_q;

        if (cfg_update) begin
            shadow_num_d  = norm_num(cfg_num);
            shadow_list_d = cfg_list;
            pending_d     = 1'b1;
        end

        if (state_q != S_IDLE) overrun_d = trig;

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d = S_CNV_PULSE;
                    cnt_d   = '0;
                end
            end

            S_CNV_PULSE: begin
                if (cnt_q == CNT_W'(CNV_HIGH - 1)) begin
                    state_d = S_WAIT_BUSY_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_BUSY_HI: begin
                if (busy_s2_q) begin
                    state_d = S_WAIT_BUSY_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(BUSY_TO)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_BUSY_LO: begin
                if (!busy_s2_q) begin
                    // Freeze the pending config for this frame; a later update stays pending.
                    state_d      = S_SHIFT;
                    cnt_d        = '0;
                    k_d          = '0;
                    scki_d       = 1'b0;
                    word_d       = '0;
                    frame_load_d = pending_q;
                    frame_num_d  = shadow_num_q;
                    frame_list_d = shadow_list_q;
                    e_d          = (pending_q && (shadow_num_q > 4'd3)) ?
                                   {shadow_num_q, 3'b000} : K_W'(24);
                    sdi_d        = sdi_bit('0, pending_q, shadow_num_q, shadow_list_q);
                    pending_d    = cfg_update;
                end else if (cnt_q == CNT_W'(BUSY_TO)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SHIFT: begin
                if (half_last) begin
                    cnt_d = '0;
                    if (k_q < e_q) scki_d = ~scki_q;
                    // Last cycle of half-period k carries the bit launched by edge k-1.
                    if ((k_q != '0) && (k_q <= K_W'(24))) word_d = {word_q[22:0], sdo_s2_q};
                    if (k_q == e_q) begin
                        state_d     = S_OUTPUT;
                        sdi_d       = 1'b0;
                        res_valid_d = 1'b1;
                        res_data_d  = word_d[23:6];
                        res_chan_d  = word_d[5:3];
                        res_span_d  = word_d[2:0];
                        seq_err_d   = cfg_valid_q && (word_d[5:0] != exp_entry);
                        if (cfg_valid_q) begin
                            if ({1'b0, ptr_q} == (act_num_q - 4'd1)) ptr_d = '0;
                            else ptr_d = ptr_q + 3'd1;
                        end
                        // New sequence takes effect from the next conversion.
                        if (frame_load_q) begin
                            act_list_d  = frame_list_q;
                            act_num_d   = frame_num_q;
                            cfg_valid_d = 1'b1;
                            ptr_d       = '0;
                        end
                    end else begin
                        k_d   = k_q + K_W'(1);
                        sdi_d = sdi_bit(k_q + K_W'(1), frame_load_q, frame_num_q, frame_list_q);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_OUTPUT: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        cnv_d   = (state_d == S_CNV_PULSE);
        ready_d = (state_d == S_IDLE);
    end

    assign cnv          = cnv_q;
    assign scki         = scki_q;
    assign sdi          = sdi_q;
    assign ready        = ready_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_chan     = res_chan_q;
    assign res_span     = res_span_q;
    assign seq_err      = seq_err_q;
    assign timeout_err  = timeout_q;
    assign trig_overrun = overrun_q;

endmodule

// File: tb/tb_ltc2333_scan_controller.sv
// Directed bench for ltc2333_scan_controller with a behavioural LTC2333 model.
module tb_ltc2333_scan_controller;

    localparam int unsigned SCK_HALF = 4;
    localparam int unsigned CNV_HIGH = 4;
    localparam int unsigned BUSY_TO  = 1023;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig;
    logic        cfg_update;
    logic [3:0]  cfg_num;
    logic [47:0] cfg_list;
    logic        cnv;
    logic        busy = 1'b0;
    logic        scki;
    logic        sdi;
    logic        sdo = 1'b0;
    logic        ready;
    logic        res_valid;
    logic [17:0] res_data;
    logic [2:0]  res_chan;
    logic [2:0]  res_span;
    logic        seq_err;
    logic        timeout_err;
    logic        trig_overrun;

    int checks   = 0;
    int failures = 0;

    // ADC model state
    logic [23:0] adc_data = 24'habcdef;
    logic        busy_en  = 1'b1;
    logic [5:0]  m_list [8];
    int          m_num    = 1;
    int          m_ptr    = 0;
    logic        m_valid  = 1'b0;
    logic [5:0]  st_list [8];
    int          st_n     = 0;
    logic [23:0] m_word   = '0;
    int          edge_cnt = 0;
    logic        m_active = 1'b0;
    logic [7:0]  m_bytes [8];
    logic [7:0]  byte_sr  = '0;
    logic        sdi_last = 1'b0;
    int          res_count = 0;

    always #5 clk = ~clk;

    ltc2333_scan_controller #(
        .SCK_HALF(SCK_HALF),
        .CNV_HIGH(CNV_HIGH),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trig        (trig),
        .cfg_update  (cfg_update),
        .cfg_num     (cfg_num),
        .cfg_list    (cfg_list),
        .cnv         (cnv),
        .busy        (busy),
        .scki        (scki),
        .sdi         (sdi),
        .sdo         (sdo),
        .ready       (ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_chan    (res_chan),
        .res_span    (res_span),
        .seq_err     (seq_err),
        .timeout_err (timeout_err),
        .trig_overrun(trig_overrun)
    );

    // Conversion start: install a received sequence, pick this word's chan/span.
    always @(posedge cnv) begin
        if (st_n > 0) begin
            for (int i = 0; i < st_n; i++) m_list[i] = st_list[i];
            m_num   = st_n;
            m_ptr   = 0;
            m_valid = 1'b1;
            st_n    = 0;
        end
        if (m_valid) begin
            m_word = {adc_data[23:6], m_list[m_ptr]};
            m_ptr  = (m_ptr + 1) % m_num;
        end else begin
            m_word = {adc_data[23:6], 6'd0};
        end
        edge_cnt = 0;
        byte_sr  = '0;
        for (int i = 0; i < 8; i++) m_bytes[i] = 8'h00;
        m_active = 1'b1;
    end

    // BUSY high for a fixed conversion time.
    always @(posedge cnv) begin
        if (busy_en) begin
            @(posedge clk);
            busy <= 1'b1;
            repeat (30) @(posedge clk);
            busy <= 1'b0;
        end
    end

    always @(negedge clk) sdi_last = sdi;

    always @(negedge clk) if (res_valid === 1'b1) res_count++;

    // Each SCKI edge: take the SDI bit, launch the next SDO bit.
    always @(posedge scki or negedge scki) begin
        if (m_active) begin
            byte_sr = {byte_sr[6:0], sdi_last};
            if ((edge_cnt % 8 == 7) && (edge_cnt < 64)) begin
                m_bytes[edge_cnt / 8] = byte_sr;
                if (byte_sr[7] && (st_n < 8)) begin
                    st_list[st_n] = byte_sr[5:0];
                    st_n++;
                end
            end
            sdo <= #2 (edge_cnt < 24) ? m_word[23 - edge_cnt] : 1'b0;
            edge_cnt++;
        end
    end

    task automatic do_conv(output logic got, output logic [17:0] d, output logic [2:0] c,
                           output logic [2:0] s, output logic se);
        got = 1'b0; d = '0; c = '0; s = '0; se = 1'b0;
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (res_valid === 1'b1) begin
                got = 1'b1; d = res_data; c = res_chan; s = res_span; se = seq_err;
                break;
            end
            @(negedge clk);
        end
        for (int n = 0; n < 50 && ready !== 1'b1; n++) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; trig = 1'b0; cfg_update = 1'b0; cfg_num = '0; cfg_list = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cnv, scki, sdi, res_valid, seq_err, timeout_err, trig_overrun} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {cnv, scki, sdi, res_valid, seq_err, timeout_err, trig_overrun});
        end
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++;
        if ({res_data, res_chan, res_span} !== 24'h0) begin
            failures++; $display("FAIL reset_res: got %h expected 0", {res_data, res_chan, res_span});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic got, se; logic [17:0] d; logic [2:0] c, s; int r0;
        r0 = res_count;
        do_conv(got, d, c, s, se);
        checks++;
        if ({got, d, c, s, se} !== {1'b1, 18'h2AF37, 3'd0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL basic_result: got v=%b d=%h c=%0d s=%0d e=%b expected v=1 d=2af37 c=0 s=0 e=0",
                     got, d, c, s, se);
        end
        checks++;
        if (edge_cnt !== 24) begin failures++; $display("FAIL basic_edges: got %0d expected 24", edge_cnt); end
        checks++;
        if (res_count - r0 !== 1) begin
            failures++; $display("FAIL basic_count: got %0d expected 1", res_count - r0);
        end
    endtask

    task automatic test_cfg_seq;
        logic got, se; logic [17:0] d; logic [2:0] c, s;
        logic [2:0] ec, es;
        @(negedge clk);
        cfg_num = 4'd2; cfg_list = '0;
        cfg_list[5:0]  = 6'b011_111;
        cfg_list[11:6] = 6'b101_010;
        cfg_update = 1'b1;
        @(negedge clk); cfg_update = 1'b0;
        do_conv(got, d, c, s, se);
        checks++;
        if ({got, c, s, se} !== {1'b1, 3'd0, 3'd0, 1'b0}) begin
            failures++; $display("FAIL cfg_first: got v=%b c=%0d s=%0d e=%b expected v=1 c=0 s=0 e=0", got, c, s, se);
        end
        checks++;
        if (edge_cnt !== 24) begin failures++; $display("FAIL cfg_edges: got %0d expected 24", edge_cnt); end
        checks++;
        if ({m_bytes[0], m_bytes[1], m_bytes[2]} !== 24'h9FAA00) begin
            failures++; $display("FAIL cfg_sdi: got %h%h%h expected 9faa00", m_bytes[0], m_bytes[1], m_bytes[2]);
        end
        for (int i = 0; i < 4; i++) begin
            ec = (i % 2 == 0) ? 3'd3 : 3'd5;
            es = (i % 2 == 0) ? 3'd7 : 3'd2;
            do_conv(got, d, c, s, se);
            checks++;
            if ({got, c, s, se} !== {1'b1, ec, es, 1'b0}) begin
                failures++;
                $display("FAIL cfg_seq%0d: got v=%b c=%0d s=%0d e=%b expected v=1 c=%0d s=%0d e=0",
                         i + 2, got, c, s, se, ec, es);
            end
        end
    endtask

    task automatic test_cfg_full;
        logic got, se; logic [17:0] d; logic [2:0] c, s;
        @(negedge clk);
        cfg_num = 4'd8;
        for (int i = 0; i < 8; i++) cfg_list[6*i +: 6] = {3'(i), 3'(7 - i)};
        cfg_update = 1'b1;
        @(negedge clk); cfg_update = 1'b0;
        do_conv(got, d, c, s, se);
        checks++;
        if (edge_cnt !== 64) begin failures++; $display("FAIL full_edges: got %0d expected 64", edge_cnt); end
        checks++;
        if ({got, d, c, s, se} !== {1'b1, 18'h2AF37, 3'd3, 3'd7, 1'b0}) begin
            failures++;
            $display("FAIL full_result: got v=%b d=%h c=%0d s=%0d e=%b expected v=1 d=2af37 c=3 s=7 e=0",
                     got, d, c, s, se);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m_bytes[i] !== {2'b10, 3'(i), 3'(7 - i)}) begin
                failures++;
                $display("FAIL full_byte%0d: got %h expected %h", i, m_bytes[i], {2'b10, 3'(i), 3'(7 - i)});
            end
        end
        do_conv(got, d, c, s, se);
        checks++;
        if ({got, c, s, se} !== {1'b1, 3'd0, 3'd7, 1'b0}) begin
            failures++; $display("FAIL full_next: got v=%b c=%0d s=%0d e=%b expected v=1 c=0 s=7 e=0", got, c, s, se);
        end
    endtask

    task automatic test_seq_err;
        logic got, se; logic [17:0] d; logic [2:0] c, s;
        m_ptr = 3;
        do_conv(got, d, c, s, se);
        checks++;
        if ({got, c, s, se} !== {1'b1, 3'd3, 3'd4, 1'b1}) begin
            failures++; $display("FAIL seqerr_set: got v=%b c=%0d s=%0d e=%b expected v=1 c=3 s=4 e=1", got, c, s, se);
        end
        m_ptr = 2;
        do_conv(got, d, c, s, se);
        checks++;
        if ({got, c, s, se} !== {1'b1, 3'd2, 3'd5, 1'b0}) begin
            failures++; $display("FAIL seqerr_clr: got v=%b c=%0d s=%0d e=%b expected v=1 c=2 s=5 e=0", got, c, s, se);
        end
    endtask

    task automatic test_timeout;
        int r0; int n; logic seen;
        busy_en = 1'b0; r0 = res_count; seen = 1'b0; n = 0;
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        for (int i = 1; i <= int'(BUSY_TO) + 200; i++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin seen = 1'b1; n = i; break; end
        end
        checks++;
        if (seen !== 1'b1 || n < int'(BUSY_TO) + 1 || n > int'(BUSY_TO + CNV_HIGH) + 8) begin
            failures++; $display("FAIL timeout_pulse: got seen=%b at %0d expected near %0d", seen, n, BUSY_TO + 5);
        end
        @(negedge clk);
        checks++;
        if ({timeout_err, ready, cnv} !== 3'b010) begin
            failures++; $display("FAIL timeout_after: got %b expected 010", {timeout_err, ready, cnv});
        end
        checks++;
        if (res_count !== r0) begin failures++; $display("FAIL timeout_nores: got %0d expected %0d", res_count, r0); end
        busy_en = 1'b1;
    endtask

    task automatic test_back_to_back;
        int r0; logic hit;
        r0 = res_count; hit = 1'b0;
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (scki === 1'b1) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (hit !== 1'b1) begin failures++; $display("FAIL b2b_shift: got no scki expected scki high"); end
        trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        checks++;
        if (trig_overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun: got %b expected 1", trig_overrun); end
        @(negedge clk);
        checks++;
        if (trig_overrun !== 1'b0) begin failures++; $display("FAIL b2b_pulse: got %b expected 0", trig_overrun); end
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (res_valid === 1'b1) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        checks++;
        if ({hit, trig_overrun, ready} !== 3'b111) begin
            failures++; $display("FAIL b2b_output_trig: got %b expected 111", {hit, trig_overrun, ready});
        end
        repeat (400) @(negedge clk);
        checks++;
        if ({res_count - r0, ready} !== {32'd1, 1'b1}) begin
            failures++; $display("FAIL b2b_count: got %0d ready=%b expected 1 ready=1", res_count - r0, ready);
        end
    endtask

    task automatic test_reset_mid_shift;
        int r0; logic hit;
        r0 = res_count; hit = 1'b0;
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (scki === 1'b1) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({hit, scki, ready, res_valid, cnv} !== 5'b10100) begin
            failures++; $display("FAIL rst_shift: got %b expected 10100", {hit, scki, ready, res_valid, cnv});
        end
        reset = 1'b0;
        repeat (400) @(negedge clk);
        checks++;
        if (res_count !== r0) begin failures++; $display("FAIL rst_nores: got %0d expected %0d", res_count, r0); end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_cfg_seq();
        test_cfg_full();
        test_seq_err();
        test_timeout();
        test_back_to_back();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
